// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding and idle-line defaults, common to TX and RX.
package spi_pkg;

    // Mode number = {CPOL, CPHA}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    // Idle line level; the idle word is this bit replicated, and it is also
    // the fill bit shifted in behind outgoing data.
    localparam logic IDLE_FILL = 1'b1;

    function automatic spi_mode_e make_mode(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

    function automatic logic mode_cpol(input spi_mode_e mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_e mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous TX FIFO with head peek, explicit pop, occupancy, full and empty.
module spi_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_wr;
    logic                  do_pop;

    assign do_wr  = wr_en & ~full;
    assign do_pop = pop & ~empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable;
    // reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave transmit engine: synchronises SCK/SSEL, decodes launch/sample
// events for the configured mode and shifts FIFO words out on MISO.
// A word is peeked at load and popped only when its first bit is sampled,
// so a word loaded but never clocked stays queued.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    FIFO_DEPTH   = 4,
    parameter bit                    CPOL         = 1'b0,
    parameter bit                    CPHA         = 1'b0,
    parameter bit                    MSB_FIRST    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = {DATA_WIDTH{IDLE_FILL}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        SCK,
    input  logic                        SSEL,
    output logic                        MISO,
    input  logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        word_sent,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam spi_mode_e       MODE     = make_mode(CPOL, CPHA);

    logic [2:0]            sck_sync;
    logic [2:0]            ssel_sync;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  ssel_fall;
    logic                  ssel_active;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  launch;
    logic                  sample;
    logic                  load;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic                  from_fifo;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_wr;
    logic                  fifo_pop;

    // Three-flop synchronisers; reset to the idle bus levels so that release
    // of reset does not fabricate an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {3{CPOL}};
            ssel_sync <= 3'b111;
        end else begin
            sck_sync  <= {sck_sync[1:0], SCK};
            ssel_sync <= {ssel_sync[1:0], SSEL};
        end
    end

    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1] & sck_sync[2];
    assign ssel_fall   = ~ssel_sync[1] & ssel_sync[2];
    assign ssel_active = ~ssel_sync[1];

    assign lead_edge  = mode_cpol(MODE) ? sck_fall : sck_rise;
    assign trail_edge = mode_cpol(MODE) ? sck_rise : sck_fall;

    // CPHA=0 must present bit 0 before the first leading edge, so frame start
    // is itself a launch; CPHA=1 launches on the leading edge.
    assign launch = ssel_active & (mode_cpha(MODE) ? lead_edge : (ssel_fall | trail_edge));
    assign sample = ssel_active & (mode_cpha(MODE) ? trail_edge : lead_edge);

    assign load     = launch & (bit_cnt == '0);
    assign underrun = load & fifo_empty;
    assign fifo_pop = sample & (bit_cnt == '0) & from_fifo;
    assign fifo_wr  = tx_valid & tx_ready;
    assign tx_ready = ~fifo_full;

    // Shift register: word load at bit 0, otherwise shift toward the output end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= IDLE_PATTERN;
            from_fifo <= 1'b0;
        end else if (load) begin
            shreg     <= fifo_empty ? IDLE_PATTERN : fifo_head;
            from_fifo <= ~fifo_empty;
        end else if (launch) begin
            if (MSB_FIRST) shreg <= {shreg[DATA_WIDTH-2:0], IDLE_FILL};
            else           shreg <= {IDLE_FILL, shreg[DATA_WIDTH-1:1]};
        end
    end

    // Bit counter advances on each sample and wraps at the word boundary;
    // deselect abandons any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            word_sent <= 1'b0;
        end else begin
            word_sent <= sample & (bit_cnt == LAST_BIT);
            if (!ssel_active)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

    assign MISO = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];

    spi_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (tx_data),
        .wr_en   (fifo_wr),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a mode-0 MSB-first instance and a mode-3 LSB-first
// instance, each driven by a behavioural SPI master. Expected words are queued
// when a frame is issued; a monitor pops and compares on every word_sent.
module tb_spi_slave_tx;

    logic clk = 1'b0;
    logic rst_n;

    logic       sck0, ssel0, miso0, tx_valid0, tx_ready0, word_sent0, underrun0;
    logic [7:0] tx_data0;
    logic [2:0] fifo_level0;

    logic       sck3, ssel3, miso3, tx_valid3, tx_ready3, word_sent3, underrun3;
    logic [7:0] tx_data3;
    logic [2:0] fifo_level3;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp3[$];
    logic [7:0] rx_last0, rx_last3;
    int ws_cnt0 = 0, ur_cnt0 = 0, ws_cnt3 = 0, ur_cnt3 = 0;

    always #5 clk = ~clk;

    spi_slave_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .SCK(sck0), .SSEL(ssel0), .MISO(miso0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .word_sent(word_sent0), .underrun(underrun0), .fifo_level(fifo_level0)
    );

    spi_slave_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n), .SCK(sck3), .SSEL(ssel3), .MISO(miso3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
        .word_sent(word_sent3), .underrun(underrun3), .fifo_level(fifo_level3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each word_sent consumes one expected word.
    always @(negedge clk) begin
        if (word_sent0 === 1'b1) begin
            ws_cnt0++;
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx0_unexpected: got word %0h, expected none queued", rx_last0);
            end else check("rx0_word", {24'h0, rx_last0}, {24'h0, exp0.pop_front()});
        end
        if (word_sent3 === 1'b1) begin
            ws_cnt3++;
            if (exp3.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx3_unexpected: got word %0h, expected none queued", rx_last3);
            end else check("rx3_word", {24'h0, rx_last3}, {24'h0, exp3.pop_front()});
        end
        if (underrun0 === 1'b1) ur_cnt0++;
        if (underrun3 === 1'b1) ur_cnt3++;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr0(input logic [7:0] d);
        @(negedge clk); tx_data0 = d; tx_valid0 = 1'b1;
        @(negedge clk); tx_valid0 = 1'b0;
    endtask

    task automatic wr3(input logic [7:0] d);
        @(negedge clk); tx_data3 = d; tx_valid3 = 1'b1;
        @(negedge clk); tx_valid3 = 1'b0;
    endtask

    // Mode 0 master, MSB first: sample MISO just before each rising edge.
    task automatic frame0(input int nbits, input bit raise, output logic [31:0] tbits);
        logic [7:0] w;
        w = '0; tbits = '0;
        @(negedge clk); ssel0 = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            tbits = {tbits[30:0], miso0};
            w     = {w[6:0], miso0};
            if (i % 8 == 7) rx_last0 = w;
            sck0 = 1'b1; repeat (8) @(negedge clk);
            sck0 = 1'b0; repeat (8) @(negedge clk);
        end
        if (raise) begin
            ssel0 = 1'b1; repeat (8) @(negedge clk);
        end
    endtask

    // Mode 3 master, LSB first: falling edge leads, sample before rising edge.
    task automatic frame3(input int nbits, output logic [31:0] tbits);
        logic [7:0] w;
        w = '0; tbits = '0;
        @(negedge clk); ssel3 = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sck3 = 1'b0; repeat (8) @(negedge clk);
            tbits      = {tbits[30:0], miso3};
            w[i % 8]   = miso3;
            if (i % 8 == 7) rx_last3 = w;
            sck3 = 1'b1; repeat (8) @(negedge clk);
        end
        ssel3 = 1'b1; repeat (8) @(negedge clk);
    endtask

    logic [31:0] tb;
    int ws0, ur0, ws3, ur3;
    logic [7:0] fill_words [5];

    initial begin
        rst_n = 1'b0;
        sck0 = 1'b0; ssel0 = 1'b1; tx_valid0 = 1'b0; tx_data0 = '0;
        sck3 = 1'b1; ssel3 = 1'b1; tx_valid3 = 1'b0; tx_data3 = '0;
        fill_words[0] = 8'hA1; fill_words[1] = 8'hB2; fill_words[2] = 8'hC3;
        fill_words[3] = 8'hD4; fill_words[4] = 8'hE5;
        repeat (3) @(negedge clk);
        check("rst_miso0",      miso0,       1);
        check("rst_miso3",      miso3,       1);
        check("rst_tx_ready0",  tx_ready0,   1);
        check("rst_level0",     fifo_level0, 0);
        check("rst_word_sent0", word_sent0,  0);
        check("rst_underrun0",  underrun0,   0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0: two words in one 16-bit frame
        wr0(8'hA5); wr0(8'h3C);
        check("m0_level_after_wr", fifo_level0, 2);
        exp0.push_back(8'hA5); exp0.push_back(8'h3C);
        ws0 = ws_cnt0; ur0 = ur_cnt0;
        frame0(16, 1'b1, tb);
        check("m0_bits",       tb[15:0],        16'hA53C);
        check("m0_word_sent",  ws_cnt0 - ws0,   2);
        check("m0_level_end",  fifo_level0,     0);
        // SCK returning idle after the last bit is a trailing-edge load of an empty FIFO
        check("m0_underrun",   ur_cnt0 - ur0,   1);

        // Mode 3, LSB first: 8'h01 arrives as 1 then seven 0s
        wr3(8'h01);
        exp3.push_back(8'h01);
        ws3 = ws_cnt3; ur3 = ur_cnt3;
        frame3(8, tb);
        check("m3_time_order", tb[7:0],        8'b1000_0000);
        check("m3_word_sent",  ws_cnt3 - ws3,  1);
        check("m3_underrun",   ur_cnt3 - ur3,  0);
        check("m3_level_end",  fifo_level3,    0);

        // Mode 3, empty FIFO: idle word, single underrun
        exp3.push_back(8'hFF);
        ws3 = ws_cnt3; ur3 = ur_cnt3;
        frame3(8, tb);
        check("empty_bits",      tb[7:0],       8'hFF);
        check("empty_underrun",  ur_cnt3 - ur3, 1);
        check("empty_word_sent", ws_cnt3 - ws3, 1);

        // Fill past depth: tx_ready falls after four writes, fifth ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("full_tx_ready_%0d", i), tx_ready0, (i < 4) ? 1 : 0);
            tx_data0 = fill_words[i]; tx_valid0 = 1'b1;
        end
        @(negedge clk); tx_valid0 = 1'b0;
        check("full_tx_ready", tx_ready0,   0);
        check("full_level",    fifo_level0, 4);
        for (int i = 0; i < 4; i++) exp0.push_back(fill_words[i]);
        ws0 = ws_cnt0;
        frame0(32, 1'b1, tb);
        check("drain_bits",      tb,            32'hA1B2C3D4);
        check("drain_word_sent", ws_cnt0 - ws0, 4);
        check("drain_level",     fifo_level0,   0);

        // Abandoned partial word, then the next word in its own frame
        wr0(8'hF0); wr0(8'h5A); wr0(8'h11);
        ws0 = ws_cnt0;
        frame0(3, 1'b1, tb);
        check("partial_bits",      tb[2:0],       3'b111);
        check("partial_word_sent", ws_cnt0 - ws0, 0);
        check("partial_level",     fifo_level0,   2);
        exp0.push_back(8'h5A);
        frame0(8, 1'b1, tb);
        check("next_bits",      tb[7:0],       8'h5A);
        check("next_word_sent", ws_cnt0 - ws0, 1);
        check("peeked_stays",   fifo_level0,   1);

        // Reset mid-frame flushes the FIFO and restores idle MISO
        wr0(8'h22);
        check("pre_rst_level", fifo_level0, 2);
        frame0(3, 1'b0, tb);
        check("pre_rst_bits",  tb[2:0],     3'b000);
        check("mid_rst_level_before", fifo_level0, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_miso",     miso0,       1);
        check("mid_rst_level",    fifo_level0, 0);
        check("mid_rst_tx_ready", tx_ready0,   1);
        ssel0 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        check("exp0_drained", exp0.size(), 0);
        check("exp3_drained", exp3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_tx.md
# spi_slave_tx

Parametrised SPI slave transmit engine: streams words from an internal TX FIFO onto MISO under control of an external SPI master (SCK, SSEL). It supports all four SPI modes, configurable word width, FIFO depth and bit order, and sits between the on-chip sample/measurement producer and the SPI pins. Transmission uses peek-then-commit, so a word is popped only once the master has clocked its first bit. Empty-FIFO conditions are flagged, and the idle pattern is transmitted in their place.

## Interface
- DATA_WIDTH, 8, bits per SPI word (≥2)
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- CPOL, 0, SCK idle level
- CPHA, 0, 0: master samples on leading edge; 1: master samples on trailing edge
- MSB_FIRST, 1, 1: MSB first; 0: LSB first
- IDLE_PATTERN, all ones, word sent on underrun and driven while idle
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- SCK  input  1  SPI clock, asynchronous to clk
- SSEL  input  1  slave select, active low, asynchronous
- MISO  output  1  serial data out; no tri-state, single slave
- tx_data  input  DATA_WIDTH  word to enqueue
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  FIFO not full
- word_sent  output  1  one-cycle pulse per fully transmitted word
- underrun  output  1  one-cycle pulse when IDLE_PATTERN is loaded because the FIFO is empty
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Reset values: MISO = first-out bit of IDLE_PATTERN; tx_ready=1; word_sent=0; underrun=0; fifo_level=0. Shift register = IDLE_PATTERN; bit counter = 0.
- Synchronisers: SCK and SSEL each pass through a 3-bit shift register. Edges are decoded from bits [2:1]. SSEL active = ~SSELr[1].
- Leading edge = rising if CPOL=0, falling if CPOL=1; trailing edge is the opposite.
- Launch events:
  - CPHA=0: frame start (SSEL falling) and every trailing edge.
  - CPHA=1: every leading edge.
- Sample event: the other edge.
- At a launch event with bit counter = 0:
  - Load the shift register from the FIFO head (peek, no pop), or IDLE_PATTERN if the FIFO is empty (pulse underrun).
  - Set an internal from_fifo flag accordingly.
- At a launch event with bit counter ≠ 0: shift one position toward the output end. Fill bit is 1.
- At a sample event:
  - Increment the bit counter.
  - If the counter was 0 and from_fifo=1, pop the FIFO.
  - When the counter reaches DATA_WIDTH it wraps to 0 and word_sent pulses.
- MISO is the MSB or LSB of the shift register, per MSB_FIRST.
- SSEL inactive:
  - Bit counter is held at 0 and no shift or load occurs.
  - A partially sent word is abandoned and, having been popped, is not resent.
  - A word that was loaded but never sampled stays in the FIFO.
- FIFO write occurs when tx_valid && tx_ready. A write and a pop in the same cycle leave fifo_level unchanged. When full, tx_ready=0 and writes are ignored.
- A write in the same cycle as a load from an empty FIFO is not bypassed: that load uses IDLE_PATTERN.

## Timing
- SSEL/SCK to internal edge detection: 3 clk.
- MISO update: 1 clk after the detected launch event.
- Master requirements: SCK half-period ≥ 4 clk, and ≥ 4 clk from SSEL falling to the first SCK edge. Only then is CPHA=0 bit 0 valid before the first leading edge.
- word_sent asserts 1 clk after the detected sample edge of the last bit.
- underrun asserts in the load cycle.
- rst_n assertion mid-frame: immediate return to reset values. The FIFO is flushed.

## Structure
- Shared package spi_pkg holds the mode encoding (CPOL/CPHA) and the IDLE_PATTERN default, for reuse by the receive side.
- Sub-module spi_tx_fifo: synchronous FIFO with peek, pop, level, full and empty, parametrised by DATA_WIDTH and FIFO_DEPTH.
- The top level holds the synchronisers, edge decode, bit counter and shift register.

## Test plan
- Mode 0, 8-bit, MSB first: enqueue 8'hA5, 8'h3C, then clock a 16-bit frame. Master reads A5 3C; word_sent pulses twice; fifo_level returns to 0.
- Mode 3 (CPOL=1, CPHA=1), LSB first: enqueue 8'h01. Master reads 8'h01 as 1,0,0,0,0,0,0,0 in time order.
- Empty FIFO, 8-bit frame: master reads 8'hFF; underrun pulses once; word_sent pulses once.
- FIFO_DEPTH=4: write 5 words back-to-back. tx_ready drops after 4; the 5th is ignored; fifo_level=4.
- SSEL raised after 3 bits of 8'hF0: no word_sent. The next frame sends the following FIFO word.
- Mode 0, frame ends after exactly one word with 8'h11 still queued: 8'h11 remains in the FIFO (fifo_level=1). rst_n pulse mid-frame: MISO=1, fifo_level=0.
